// File: rtl/mmio_bus_router_pkg.sv
// mmio_bus_router_pkg: shared FSM state type, default error word and index-width helper
package mmio_bus_router_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
    localparam logic [31:0] ERR_DATA_DEF = 32'hdeadbeef;
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mmio_bus_router_if.sv
// mmio_bus_router_if: CPU data port, slave channels and error reporting of the MMIO router
interface mmio_bus_router_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                     cpu_rd;
    logic                     cpu_wr;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [DATA_W-1:0]        cpu_wdata;
    logic [3:0]               cpu_ben;
    logic [DATA_W-1:0]        cpu_rdata;
    logic                     cpu_stall;
    logic [N_CH:0]            ch_req;
    logic                     ch_we;
    logic [ADDR_W-1:0]        ch_addr;
    logic [DATA_W-1:0]        ch_wdata;
    logic [3:0]               ch_ben;
    logic [(N_CH+1)*DATA_W-1:0] ch_rdata;
    logic [N_CH:0]            ch_ack;
    logic                     err_flag;
    logic [ADDR_W-1:0]        err_addr;
    logic [7:0]               err_cnt;
    logic                     err_clr;
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_ben, ch_rdata, ch_ack, err_clr,
        output cpu_rdata, cpu_stall, ch_req, ch_we, ch_addr, ch_wdata, ch_ben, err_flag, err_addr, err_cnt
    );
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_ben, ch_rdata, ch_ack, err_clr,
        input  cpu_rdata, cpu_stall, ch_req, ch_we, ch_addr, ch_wdata, ch_ben, err_flag, err_addr, err_cnt
    );
endinterface

// File: rtl/mmio_bus_router_addr_decode.sv
// mmio_bus_router_addr_decode: base/mask region match, lowest index wins, no match selects channel N_CH
module mmio_bus_router_addr_decode #(
    parameter int                      N_CH     = 4,
    parameter int                      ADDR_W   = 30,
    parameter logic [N_CH*ADDR_W-1:0]  BASE_VEC = '0,
    parameter logic [N_CH*ADDR_W-1:0]  MASK_VEC = '0,
    parameter int                      IW       = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_CH:0]     sel_o,
    output logic [IW-1:0]     idx_o
);
    // Channel 0 sits in the most significant slice, matching the {ch0, ch1, ...} literal order
    always_comb begin
        sel_o = '0;
        sel_o[N_CH] = 1'b1;
        idx_o = IW'(N_CH);
        for (int i = N_CH - 1; i >= 0; i--)
            if (((addr_i ^ BASE_VEC[(N_CH-1-i)*ADDR_W +: ADDR_W]) & MASK_VEC[(N_CH-1-i)*ADDR_W +: ADDR_W]) == '0) begin
                sel_o = '0;
                sel_o[i] = 1'b1;
                idx_o = IW'(i);
            end
    end
endmodule

// File: rtl/mmio_bus_router.sv
// mmio_bus_router: decodes CPU data accesses onto req/ack slave channels with stall and timeout capture
module mmio_bus_router
    import mmio_bus_router_pkg::*;
#(
    parameter int                      N_CH     = 4,
    parameter int                      ADDR_W   = 30,
    parameter int                      DATA_W   = 32,
    parameter logic [N_CH*ADDR_W-1:0]  BASE_VEC = {30'h30000000, 30'h34000000, 30'h38000000, 30'h3c000000},
    parameter logic [N_CH*ADDR_W-1:0]  MASK_VEC = {4{30'h3c000000}},
    parameter int                      TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]       ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              ui_clk,
    input  logic              rst,
    mmio_bus_router_if.slave  bus
);
    localparam int IW = clog2(N_CH + 1);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_e              state_q, state_d;
    logic [N_CH:0]       req_q, req_d, dec_sel;
    logic [IW-1:0]       idx_q, idx_d, dec_idx;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, err_addr_q, err_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]          ben_q, ben_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                err_flag_q, err_flag_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                valid, same, start, ack, expire;
    mmio_bus_router_addr_decode #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .BASE_VEC(BASE_VEC), .MASK_VEC(MASK_VEC), .IW(IW)
    ) u_dec (
        .addr_i(bus.cpu_addr),
        .sel_o (dec_sel),
        .idx_o (dec_idx)
    );
    assign valid  = bus.cpu_rd | bus.cpu_wr;
    assign same   = bus.cpu_addr == addr_q;
    assign start  = valid && (state_q == S_IDLE || (state_q == S_DONE && !same));
    assign ack    = state_q == S_WAIT && |(bus.ch_ack & req_q);
    assign expire = TIMEOUT != 0 && state_q == S_WAIT && !ack && timer_q == TW'(TIMEOUT);
    // A new address in DONE stalls at once so the pipeline never sees a stale completion
    assign bus.cpu_stall = valid && !(state_q == S_DONE && same);
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        idx_d      = idx_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ben_d      = ben_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (start) begin
            state_d = S_WAIT;
            req_d   = dec_sel;
            idx_d   = dec_idx;
            we_d    = bus.cpu_wr;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            ben_d   = bus.cpu_ben;
            timer_d = '0;
        end else if (ack || expire) begin
            state_d = S_DONE;
            req_d   = '0;
            rdata_d = ack ? bus.ch_rdata[int'(idx_q)*DATA_W +: DATA_W] : ERR_DATA;
        end else if (state_q == S_WAIT) begin
            timer_d = timer_q + 1'b1;
        end else if (state_q == S_DONE && !valid) begin
            state_d = S_IDLE;
        end
        if (expire) begin
            err_flag_d = 1'b1;
            err_addr_d = err_flag_q ? err_addr_q : addr_q;
            err_cnt_d  = err_cnt_q == 8'hff ? err_cnt_q : err_cnt_q + 8'd1;
        end else if (bus.err_clr) begin
            err_flag_d = 1'b0;
            err_addr_d = '0;
            err_cnt_d  = '0;
        end
    end
    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ben_q      <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ben_q      <= ben_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
    assign bus.ch_req    = req_q;
    assign bus.ch_we     = we_q;
    assign bus.ch_addr   = addr_q;
    assign bus.ch_wdata  = wdata_q;
    assign bus.ch_ben    = ben_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_mmio_bus_router.sv
// tb_mmio_bus_router: table-driven accesses with a scoreboard, plus back-to-back, error-clear, saturation and reset sequences
module tb_mmio_bus_router;
    localparam int N = 4, AW = 30, DW = 32, TO = 8;
    localparam logic [N*AW-1:0] BASES = {30'h30000000, 30'h34000000, 30'h38000000, 30'h3c000000};
    // Channel 1 mask widened so it also covers 0x30000000, overlapping channel 0
    localparam logic [N*AW-1:0] MASKS = {30'h3c000000, 30'h38000000, 30'h3c000000, 30'h3c000000};
    typedef struct {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        int          ack_after;
        logic        noise;
        int          clr_at;
        logic [31:0] rdata;
        logic [4:0]  exp_sel;
        int          exp_wait;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_cnt;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        int          wt;
        logic [7:0]  cnt;
    } exp_t;
    logic ui_clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0, fails = 0;
    exp_t sb[$];
    vec_t tbl[9];
    always #5 ui_clk = ~ui_clk;
    mmio_bus_router_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    mmio_bus_router #(
        .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .BASE_VEC(BASES), .MASK_VEC(MASKS),
        .TIMEOUT(TO), .ERR_DATA(32'hdeadbeef)
    ) dut (
        .ui_clk(ui_clk),
        .rst   (rst),
        .bus   (bus)
    );
    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run(input vec_t v);
        exp_t e;
        int wn, sn;
        logic bad, done;
        bus.cpu_rd = 1'b1;
        bus.cpu_wr = v.wr;
        bus.cpu_addr = v.addr;
        bus.cpu_wdata = v.wdata;
        bus.cpu_ben = v.ben;
        for (int i = 0; i <= N; i++) bus.ch_rdata[i*DW +: DW] = v.exp_sel[i] ? v.rdata : ~v.rdata;
        sb.push_back('{v.exp_rdata, v.exp_wait, v.exp_cnt});
        #1 chk("stall_same_cycle", bus.cpu_stall, 1);
        wn = 0; sn = 1; bad = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            bus.ch_ack = '0;
            bus.err_clr = 1'b0;
            if (!bus.cpu_stall) done = 1; else sn++;
            if (bus.ch_req != '0) begin
                wn++;
                bad |= bus.ch_req !== v.exp_sel || bus.ch_we !== v.wr || bus.ch_addr !== v.addr
                       || bus.ch_wdata !== v.wdata || bus.ch_ben !== v.ben;
                if (v.noise && wn == 1) bus.ch_ack = ~v.exp_sel;
                if (wn == v.ack_after) bus.ch_ack = v.exp_sel;
                if (wn == v.clr_at) bus.err_clr = 1'b1;
            end
        end
        e = sb.pop_front();
        chk("completed", done, 1);
        chk("cpu_rdata", bus.cpu_rdata, e.rdata);
        chk("req_cycles", wn, e.wt);
        chk("stall_cycles", sn, e.wt + 1);
        chk("req_onehot_stable", bad, 0);
        chk("err_cnt", bus.err_cnt, e.cnt);
        tick();
        chk("done_spin", {bus.cpu_stall, bus.ch_req}, 0);
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        tick();
    endtask
    initial begin
        //          wr addr            wdata         ben  ack nz clr rdata         sel       wt rdata exp      cnt
        tbl[0] = '{1, 30'h30000010, 32'ha5a50001, 4'h3, 3, 0, 0, 32'h11110000, 5'b00001, 3, 32'h11110000, 8'd0};
        tbl[1] = '{0, 30'h00001000, 32'h00000000, 4'h0, 2, 0, 0, 32'h12345678, 5'b10000, 2, 32'h12345678, 8'd0};
        tbl[2] = '{0, 30'h3c000004, 32'h00000001, 4'hf, 0, 0, 0, 32'h22222222, 5'b01000, 9, 32'hdeadbeef, 8'd1};
        tbl[3] = '{0, 30'h30000000, 32'h00000002, 4'h1, 3, 1, 0, 32'h0badf00d, 5'b00001, 3, 32'h0badf00d, 8'd1};
        tbl[4] = '{0, 30'h34000000, 32'h00000003, 4'h2, 1, 0, 0, 32'h600df00d, 5'b00010, 1, 32'h600df00d, 8'd1};
        tbl[5] = '{0, 30'h38000abc, 32'h00000004, 4'h4, 9, 0, 0, 32'h5555aaaa, 5'b00100, 9, 32'h5555aaaa, 8'd1};
        tbl[6] = '{1, 30'h3fffffff, 32'hcafe0000, 4'hc, 0, 0, 0, 32'h33333333, 5'b01000, 9, 32'hdeadbeef, 8'd2};
        tbl[7] = '{0, 30'h2c000000, 32'h00000005, 4'h5, 4, 0, 0, 32'h44444444, 5'b10000, 4, 32'h44444444, 8'd2};
        tbl[8] = '{0, 30'h37ffffff, 32'h00000006, 4'h6, 2, 0, 0, 32'h77777777, 5'b00010, 2, 32'h77777777, 8'd2};
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_ben = '0;
        bus.ch_rdata = '0; bus.ch_ack = '0; bus.err_clr = 0;
        tick();
        tick();
        chk("rst_ch_req", bus.ch_req, 0);
        chk("rst_ch_we", bus.ch_we, 0);
        chk("rst_ch_addr", bus.ch_addr, 0);
        chk("rst_ch_wdata", bus.ch_wdata, 0);
        chk("rst_ch_ben", bus.ch_ben, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_err", {bus.err_flag, bus.err_addr, bus.err_cnt}, 0);
        chk("rst_stall", bus.cpu_stall, 0);
        rst = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) run(tbl[k]);
        chk("err_flag_sticky", bus.err_flag, 1);
        chk("err_addr_first", bus.err_addr, 30'h3c000004);
        // Back-to-back: address changes while still requesting
        bus.cpu_rd = 1'b1;
        bus.cpu_addr = 30'h34000000;
        bus.ch_rdata[DW +: DW] = 32'haaaa0001;
        #1 chk("b2b_stall0", bus.cpu_stall, 1);
        tick();
        chk("b2b_req1", bus.ch_req, 5'b00010);
        bus.ch_ack = 5'b00010;
        tick();
        bus.ch_ack = '0;
        chk("b2b_done1", bus.cpu_stall, 0);
        chk("b2b_rdata1", bus.cpu_rdata, 32'haaaa0001);
        bus.cpu_addr = 30'h34000001;
        bus.ch_rdata[DW +: DW] = 32'haaaa0002;
        #1 chk("b2b_no_spurious", bus.cpu_stall, 1);
        tick();
        chk("b2b_req2", bus.ch_req, 5'b00010);
        chk("b2b_addr2", bus.ch_addr, 30'h34000001);
        bus.ch_ack = 5'b00010;
        tick();
        bus.ch_ack = '0;
        chk("b2b_done2", bus.cpu_stall, 0);
        chk("b2b_rdata2", bus.cpu_rdata, 32'haaaa0002);
        bus.cpu_rd = 1'b0;
        tick();
        // Error clear alone, then clear coinciding with a timeout
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_err", {bus.err_flag, bus.err_addr, bus.err_cnt}, 0);
        run('{0, 30'h3c000100, 32'h0, 4'h0, 0, 0, 9, 32'h0, 5'b01000, 9, 32'hdeadbeef, 8'd1});
        chk("clr_vs_timeout_flag", bus.err_flag, 1);
        chk("clr_vs_timeout_addr", bus.err_addr, 30'h3c000100);
        for (int i = 1; i <= 300; i++)
            run('{0, 30'h3c000200, 32'h0, 4'h0, 0, 0, 0, 32'h0, 5'b01000, 9, 32'hdeadbeef,
                  8'((1 + i) > 255 ? 255 : 1 + i)});
        chk("err_cnt_sat", bus.err_cnt, 8'd255);
        chk("err_addr_kept", bus.err_addr, 30'h3c000100);
        // Reset in the middle of a WAIT
        bus.cpu_rd = 1'b1;
        bus.cpu_addr = 30'h30000020;
        tick();
        tick();
        chk("midwait_req", bus.ch_req, 5'b00001);
        rst = 1'b0;
        tick();
        chk("rstwait_req", bus.ch_req, 0);
        chk("rstwait_err", {bus.err_flag, bus.err_addr, bus.err_cnt}, 0);
        chk("rstwait_rdata", bus.cpu_rdata, 0);
        chk("rstwait_addr", bus.ch_addr, 0);
        bus.cpu_rd = 1'b0;
        rst = 1'b1;
        tick();
        chk("rstwait_idle", {bus.cpu_stall, bus.ch_req}, 0);
        run(tbl[1]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
